inst_fetch_unit: RTL and testbench

//   Fetch stage feeding the central control decoder and the datapath: holds the PC, drives a
//   req/ready instruction-memory handshake, presents one instruction per issue cycle, and

---
 rtl/inst_fetch_unit_if.sv | 21 ++
 rtl/inst_fetch_unit.sv | 103 ++++++++++
 tb/tb_inst_fetch_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
interface inst_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ready handshake, issues one instruction
// at a time and resolves the next PC from jump/branch codes; halts on a misaligned target.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rstn,
    inst_fetch_unit_if.master         imem,
    input  logic                      stall,
    input  logic [1:0]                Jump,
    input  logic [1:0]                Branch,
    input  logic                      Zero,
    input  logic [31:0]               reg_target,
    output logic [31:0]               inst,
    output logic                      inst_valid,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    output logic [31:0]               instret,
    output logic                      halted,
    output logic [31:0]               bad_target
);

    typedef enum logic [1:0] {StReq, StIssue, StHalt} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] instret_q;
    logic        valid_q;
    logic        halted_q;
    logic [31:0] bad_q;

    logic [31:0] pc_plus4_w;
    logic [31:0] br_off;
    logic        br_taken;
    logic [31:0] npc;

    always_comb begin
        pc_plus4_w = pc_q + 32'd4;
        br_off     = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
        br_taken   = ((Branch == 2'd1) && Zero) || ((Branch == 2'd2) && !Zero);
        npc        = pc_plus4_w;
        if (Jump == 2'd1) begin
            npc = {pc_plus4_w[31:28], inst_q[25:0], 2'b00};
        end else if (Jump == 2'd2) begin
            npc = reg_target;
        end else if (br_taken) begin
            npc = pc_plus4_w + br_off;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            instret_q <= 32'h0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            bad_q     <= 32'h0;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (imem.imem_ready) begin
                        inst_q  <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        if (npc[1:0] != 2'b00) begin
                            halted_q <= 1'b1;
                            bad_q    <= npc;
                            state_q  <= StHalt;
                        end else begin
                            pc_q      <= npc;
                            instret_q <= instret_q + 32'd1;
                            state_q   <= StReq;
                        end
                    end
                end
                StHalt: begin
                end
                default: state_q <= StHalt;
            endcase
        end
    end

    // Reset state is StReq, so the request must be masked while rstn is held low.
    assign imem.imem_req  = rstn && (state_q == StReq);
    assign imem.imem_addr = pc_q;

    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_w;
    assign instret    = instret_q;
    assign halted     = halted_q;
    assign bad_target = bad_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table plus next-address scoreboard.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic [1:0]  Jump;
    logic [1:0]  Branch;
    logic        Zero;
    logic [31:0] reg_target;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
    logic        halted;
    logic [31:0] bad_target;

    inst_fetch_unit_if imem ();

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .imem       (imem.master),
        .stall      (stall),
        .Jump       (Jump),
        .Branch     (Branch),
        .Zero       (Zero),
        .reg_target (reg_target),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instret    (instret),
        .halted     (halted),
        .bad_target (bad_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  jump;
        logic [1:0]  branch;
        logic        zero;
        logic [31:0] regt;
        int          rwait;
        int          stl;
        logic [31:0] exp_npc;
        logic        halt;
    } vec_t;

    vec_t        vt[16];
    logic [31:0] sb[$];
    int          n_chk;
    int          n_err;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] popped;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, "_req"}, {31'h0, imem.imem_req}, 32'h0);
        chk({tag, "_instret"}, instret, 32'h0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
        chk({tag, "_bad"}, bad_target, 32'h0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rstn = 1'b0;
        stall = 1'b0;
        Jump = 2'd0;
        Branch = 2'd0;
        Zero = 1'b0;
        reg_target = 32'h0;
        imem.imem_ready = 1'b1;
        imem.imem_rdata = 32'h0;

        // inst, jump, branch, zero, regt, ready wait, stall cycles, expected next pc, halt
        vt[0]  = '{32'h0000_0000, 2'd0, 2'd0, 1'b0, 32'h0, 0, 0, 32'h0000_0004, 1'b0};
        vt[1]  = '{32'h0000_0000, 2'd0, 2'd0, 1'b0, 32'h0, 1, 0, 32'h0000_0008, 1'b0};
        vt[2]  = '{32'h0000_0000, 2'd0, 2'd0, 1'b0, 32'h0, 3, 2, 32'h0000_000C, 1'b0};
        vt[3]  = '{32'h0000_0000, 2'd0, 2'd0, 1'b0, 32'h0, 0, 1, 32'h0000_0010, 1'b0};
        vt[4]  = '{32'h1000_FFFF, 2'd0, 2'd1, 1'b1, 32'h0, 0, 0, 32'h0000_0010, 1'b0};
        vt[5]  = '{32'h1000_FFFF, 2'd0, 2'd1, 1'b0, 32'h0, 0, 0, 32'h0000_0014, 1'b0};
        vt[6]  = '{32'h1400_0003, 2'd0, 2'd2, 1'b0, 32'h0, 0, 0, 32'h0000_0024, 1'b0};
        vt[7]  = '{32'h1400_0003, 2'd0, 2'd2, 1'b1, 32'h0, 0, 0, 32'h0000_0028, 1'b0};
        vt[8]  = '{32'h0000_0000, 2'd2, 2'd0, 1'b0, 32'h3000_0000, 0, 0, 32'h3000_0000, 1'b0};
        vt[9]  = '{32'h0800_0100, 2'd1, 2'd0, 1'b0, 32'h0, 0, 0, 32'h3000_0400, 1'b0};
        vt[10] = '{32'h0800_0010, 2'd1, 2'd1, 1'b1, 32'h0, 0, 0, 32'h3000_0040, 1'b0};
        vt[11] = '{32'h1000_0010, 2'd3, 2'd3, 1'b0, 32'h0, 0, 0, 32'h3000_0044, 1'b0};
        vt[12] = '{32'h0000_0000, 2'd2, 2'd0, 1'b0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1'b0};
        vt[13] = '{32'h0000_0000, 2'd0, 2'd0, 1'b0, 32'h0, 0, 0, 32'h0000_0000, 1'b0};
        vt[14] = '{32'h1000_FFFF, 2'd0, 2'd1, 1'b1, 32'h0, 0, 0, 32'h0000_0000, 1'b0};
        vt[15] = '{32'h0000_0000, 2'd2, 2'd0, 1'b0, 32'h0000_0402, 0, 0, 32'h0000_0402, 1'b1};

        #3;
        chk_reset("por");

        // Zero-wait sequential nops: REQ and ISSUE alternate, addr steps by 4.
        @(negedge clk);
        rstn = 1'b1;
        #1;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            chk("seq_req", {31'h0, imem.imem_req}, {31'h0, (k % 2 == 0)});
            chk("seq_valid", {31'h0, inst_valid}, {31'h0, (k % 2 == 1)});
            chk("seq_instret", instret, k / 2);
            if (k % 2 == 0) chk("seq_addr", imem.imem_addr, 32'(4 * (k / 2)));
        end

        // Reset while waiting in REQ.
        imem.imem_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_reset("rst_req");
        @(negedge clk);
        rstn = 1'b1;
        #1;

        exp_pc = 32'h0;
        exp_ret = 32'h0;
        for (int i = 0; i < 16; i++) begin
            for (int n = 0; n < 20 && !imem.imem_req; n++) @(negedge clk);
            chk("req_timeout", {31'h0, imem.imem_req}, 32'h1);
            if (!imem.imem_req) break;
            if (sb.size() > 0) begin
                popped = sb.pop_front();
                chk("next_addr", imem.imem_addr, popped);
            end
            chk("pc", pc, exp_pc);
            chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("instret", instret, exp_ret);
            for (int w = 0; w < vt[i].rwait; w++) begin
                imem.imem_ready = 1'b0;
                imem.imem_rdata = 32'hBAD0_0001;
                @(negedge clk);
                chk("wait_addr", imem.imem_addr, exp_pc);
                chk("wait_req", {31'h0, imem.imem_req}, 32'h1);
            end
            imem.imem_ready = 1'b1;
            imem.imem_rdata = vt[i].inst;
            @(negedge clk);
            imem.imem_ready = 1'b0;
            imem.imem_rdata = 32'hBAD0_0002;
            chk("issue_valid", {31'h0, inst_valid}, 32'h1);
            chk("issue_inst", inst, vt[i].inst);
            // Misaligned jr during stall must be ignored.
            for (int s = 0; s < vt[i].stl; s++) begin
                stall = 1'b1;
                Jump = 2'd2;
                reg_target = 32'h0000_0101;
                @(negedge clk);
                chk("stall_valid", {31'h0, inst_valid}, 32'h1);
                chk("stall_pc", pc, exp_pc);
                chk("stall_instret", instret, exp_ret);
                chk("stall_halted", {31'h0, halted}, 32'h0);
            end
            stall = 1'b0;
            Jump = vt[i].jump;
            Branch = vt[i].branch;
            Zero = vt[i].zero;
            reg_target = vt[i].regt;
            if (!vt[i].halt) sb.push_back(vt[i].exp_npc);
            @(negedge clk);
            Jump = 2'd0;
            Branch = 2'd0;
            Zero = 1'b0;
            reg_target = 32'h0;
            if (vt[i].halt) begin
                chk("halt_flag", {31'h0, halted}, 32'h1);
                chk("halt_bad", bad_target, vt[i].exp_npc);
                chk("halt_pc", pc, exp_pc);
                chk("halt_instret", instret, exp_ret);
            end else begin
                exp_pc = vt[i].exp_npc;
                exp_ret = exp_ret + 32'd1;
            end
        end

        imem.imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_req", {31'h0, imem.imem_req}, 32'h0);
            chk("halt_valid", {31'h0, inst_valid}, 32'h0);
            chk("halt_hold_pc", pc, exp_pc);
            chk("halt_sticky", {31'h0, halted}, 32'h1);
        end

        // Reset while halted.
        rstn = 1'b0;
        #1;
        chk_reset("rst_halt");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
